// File: rtl/call_panel.sv
// call_panel: hall-call request side of the elevator controller.
// Each raw button is synchronised and debounced; a debounced press latches a
// request LED. A service FSM clears a floor's request once the car has stood
// at that floor, door open and not moving, for DWELL_CYCLES consecutive edges.
module call_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  input  logic floor1,
  input  logic floor2,
  input  logic floor3,
  input  logic door,
  input  logic moving,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic pending
);

  localparam logic [7:0] DEB_LIM   = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] DWELL_LIM = 8'(DWELL_CYCLES);

  typedef enum logic [1:0] {WAIT = 2'd0, DWELL = 2'd1, HOLD = 2'd2} state_t;

  // Unsigned 8-bit increment that sticks at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Index of the (single) floor in service.
  function automatic logic [1:0] floor_idx(input logic [2:0] m);
    if (m[2]) return 2'd2;
    if (m[1]) return 2'd1;
    return 2'd0;
  endfunction

  logic [2:0] btn, floors;
  logic [2:0] sync_p0, sync_p1, db;
  logic [7:0] dbc [3];
  logic [2:0] press, svc, sel_mask, absorb, clr, led;
  logic       floor_ok, svc_sel;
  state_t     state;
  logic [1:0] sel;
  logic [7:0] dcnt;

  assign btn      = {btn3, btn2, btn1};
  assign floors   = {floor3, floor2, floor1};
  assign floor_ok = (floors == 3'b001) || (floors == 3'b010) || (floors == 3'b100);
  assign svc      = (floor_ok && door && !moving) ? floors : 3'b000;
  assign sel_mask = 3'b001 << sel;
  assign svc_sel  = |(svc & sel_mask);
  assign absorb   = (state != WAIT) ? (press & sel_mask) : 3'b000;

  // Press event: debounced level is about to rise on this edge.
  always_comb begin
    press = '0;
    for (int i = 0; i < 3; i++)
      press[i] = sync_p1[i] & ~db[i] & (sat_inc(dbc[i]) >= DEB_LIM);
  end

  // Clearing edge for the serviced floor; an absorbed press restarts the dwell instead.
  always_comb begin
    clr = '0;
    if (state == WAIT && (|svc) && (8'd1 >= DWELL_LIM))
      clr = svc;
    else if (state == DWELL && svc_sel && !(|absorb) && (sat_inc(dcnt) >= DWELL_LIM))
      clr = sel_mask;
  end

  // Two-flop synchronisers and per-button stability counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      for (int i = 0; i < 3; i++) dbc[i] <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == db[i]) begin
          dbc[i] <= '0;
        end else if (sat_inc(dbc[i]) >= DEB_LIM) begin
          db[i]  <= sync_p1[i];
          dbc[i] <= '0;
        end else begin
          dbc[i] <= sat_inc(dbc[i]);
        end
      end
    end
  end

  // Service FSM with dwell counter, plus the request latches it clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
      sel   <= 2'd0;
      dcnt  <= '0;
      led   <= '0;
    end else begin
      led <= (led | (press & ~absorb)) & ~clr;
      case (state)
        WAIT: begin
          if (|svc) begin
            sel   <= floor_idx(svc);
            dcnt  <= 8'd1;
            state <= (|clr) ? HOLD : DWELL;
          end else begin
            dcnt <= '0;
          end
        end
        DWELL: begin
          if (!svc_sel) begin
            state <= WAIT;
            dcnt  <= '0;
          end else if (|absorb) begin
            dcnt <= 8'd1;
          end else begin
            dcnt <= sat_inc(dcnt);
            if (|clr) state <= HOLD;
          end
        end
        HOLD: begin
          if (!svc_sel) begin
            state <= WAIT;
            dcnt  <= '0;
          end
        end
        default: begin
          state <= WAIT;
          dcnt  <= '0;
        end
      endcase
    end
  end

  // Summary flag, one cycle behind the request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= 1'b0;
    else     pending <= |led;
  end

  assign led1 = led[0];
  assign led2 = led[1];
  assign led3 = led[2];

endmodule
